// File: rtl/cache_miss_arbiter_if.sv
// rtl/cache_miss_arbiter_if.sv - cache/memory bundle between the I/D caches, the miss arbiter and unified memory.
// master is the arbiter's side; slave is the caches-plus-memory side.
interface cache_miss_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 3
);
  logic              imiss;
  logic [ADDR_W-1:0] imiss_addr;
  logic              dmiss;
  logic [ADDR_W-1:0] dmiss_addr;
  logic              dwrite;
  logic [ADDR_W-1:0] dwrite_addr;
  logic [15:0]       dwrite_data;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_data_valid;
  logic [15:0]       mem_rdata;
  logic              fill_we_i;
  logic              fill_we_d;
  logic [WORD_W-1:0] fill_word;
  logic [15:0]       fill_data;
  logic              tag_we_i;
  logic              tag_we_d;
  logic              istall;
  logic              dstall;

  modport master (
    input  imiss, imiss_addr, dmiss, dmiss_addr, dwrite, dwrite_addr, dwrite_data,
    input  mem_data_valid, mem_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output fill_we_i, fill_we_d, fill_word, fill_data, tag_we_i, tag_we_d,
    output istall, dstall
  );

  modport slave (
    output imiss, imiss_addr, dmiss, dmiss_addr, dwrite, dwrite_addr, dwrite_data,
    output mem_data_valid, mem_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  fill_we_i, fill_we_d, fill_word, fill_data, tag_we_i, tag_we_d,
    input  istall, dstall
  );
endinterface

// File: rtl/cache_miss_arbiter.sv
// rtl/cache_miss_arbiter.sv - arbitrates I/D misses and write-through stores onto unified memory.
// Memory request outputs are registered; fill/tag strobes follow mem_data_valid in the same cycle.
module cache_miss_arbiter #(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_miss_arbiter_if.master bus
);
  localparam int WORD_W = $clog2(WORDS_PER_BLOCK);
  localparam int BASE_W = ADDR_W - WORD_W - 1;

  localparam logic [WORD_W:0]   ISSUE_ONE  = (WORD_W+1)'(1);
  localparam logic [WORD_W:0]   ISSUE_MAX  = (WORD_W+1)'(WORDS_PER_BLOCK);
  localparam logic [WORD_W-1:0] RECV_ONE   = WORD_W'(1);
  localparam logic [WORD_W-1:0] RECV_LAST  = WORD_W'(WORDS_PER_BLOCK - 1);

  if (MEM_LATENCY < 1 || WORDS_PER_BLOCK < 2 || (1 << WORD_W) != WORDS_PER_BLOCK) begin : g_bad_cfg
    $error("cache_miss_arbiter: unsupported MEM_LATENCY/WORDS_PER_BLOCK");
  end

  typedef enum logic [1:0] {IDLE, FILL_D, FILL_I, STORE} state_e;

  state_e              state_q, state_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [WORD_W:0]     issue_q, issue_d;
  logic [WORD_W-1:0]   recv_q, recv_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         mem_wdata_q, mem_wdata_d;

  logic filling;
  logic beat;
  logic last_beat;

  // Beats arriving outside a fill (e.g. stale data after reset) are dropped here.
  assign filling   = (state_q == FILL_D) || (state_q == FILL_I);
  assign beat      = filling && bus.mem_data_valid;
  assign last_beat = beat && (recv_q == RECV_LAST);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_d     = issue_q;
    recv_d      = recv_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        // D side belongs to the older instruction, so it wins over the I side.
        if (bus.dmiss) begin
          state_d    = FILL_D;
          base_d     = bus.dmiss_addr[ADDR_W-1:WORD_W+1];
          mem_en_d   = 1'b1;
          mem_addr_d = {bus.dmiss_addr[ADDR_W-1:WORD_W+1], {(WORD_W+1){1'b0}}};
          issue_d    = ISSUE_ONE;
        end else if (bus.dwrite) begin
          state_d     = STORE;
          mem_en_d    = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = bus.dwrite_addr;
          mem_wdata_d = bus.dwrite_data;
        end else if (bus.imiss) begin
          state_d    = FILL_I;
          base_d     = bus.imiss_addr[ADDR_W-1:WORD_W+1];
          mem_en_d   = 1'b1;
          mem_addr_d = {bus.imiss_addr[ADDR_W-1:WORD_W+1], {(WORD_W+1){1'b0}}};
          issue_d    = ISSUE_ONE;
        end
      end
      FILL_D, FILL_I: begin
        if (issue_q < ISSUE_MAX) begin
          mem_en_d   = 1'b1;
          mem_addr_d = {base_q, issue_q[WORD_W-1:0], 1'b0};
          issue_d    = issue_q + ISSUE_ONE;
        end
        if (beat) begin
          recv_d = recv_q + RECV_ONE;
        end
        if (last_beat) begin
          state_d  = IDLE;
          issue_d  = '0;
          recv_d   = '0;
          mem_en_d = 1'b0;
        end
      end
      STORE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_q     <= '0;
      recv_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_q     <= issue_d;
      recv_q      <= recv_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign bus.fill_we_i = beat && (state_q == FILL_I);
  assign bus.fill_we_d = beat && (state_q == FILL_D);
  assign bus.fill_word = beat ? recv_q : '0;
  assign bus.fill_data = beat ? bus.mem_rdata : 16'h0000;
  assign bus.tag_we_i  = last_beat && (state_q == FILL_I);
  assign bus.tag_we_d  = last_beat && (state_q == FILL_D);

  // Stalls include the raw request so the pipeline freezes in the detect cycle.
  assign bus.istall = bus.imiss || (state_q == FILL_I);
  assign bus.dstall = bus.dmiss || bus.dwrite || (state_q == FILL_D) || (state_q == STORE);
endmodule

// File: tb/tb_cache_miss_arbiter.sv
// tb/tb_cache_miss_arbiter.sv - scoreboard bench for cache_miss_arbiter with a pipelined memory model.
module tb_cache_miss_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_miss_arbiter_if bus ();

  cache_miss_arbiter #(.ADDR_W(16), .WORDS_PER_BLOCK(8), .MEM_LATENCY(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit gap_mode = 1'b0;
  int gap_cnt = 0;
  int fill_i_cnt = 0;
  int fill_d_cnt = 0;

  int          pend_cyc[$];
  logic [15:0] pend_addr[$];
  logic [32:0] exp_mem[$];
  logic [22:0] exp_fill[$];
  logic [32:0] m_exp;
  logic [22:0] f_exp;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_fill(input bit ic, input logic [15:0] addr);
    logic [15:0] a;
    for (int k = 0; k < 8; k++) begin
      a = {addr[15:4], 3'(k), 1'b0};
      exp_mem.push_back({1'b0, a, 16'h0000});
      exp_fill.push_back({ic, ~ic, ic && (k == 7), ~ic && (k == 7), 3'(k), mdata(a)});
    end
  endtask

  // Pipelined memory: read issued in cycle c returns no earlier than c+4, optionally with gaps.
  initial begin
    bus.mem_data_valid = 1'b0;
    bus.mem_rdata = 16'hDEAD;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.mem_data_valid = 1'b0;
      bus.mem_rdata = 16'hDEAD;
      if (pend_cyc.size() != 0 && (cyc - pend_cyc[0]) >= 4) begin
        if (gap_cnt > 0) begin
          gap_cnt--;
        end else begin
          bus.mem_data_valid = 1'b1;
          bus.mem_rdata = mdata(pend_addr[0]);
          void'(pend_cyc.pop_front());
          void'(pend_addr.pop_front());
          gap_cnt = gap_mode ? int'($urandom_range(0, 3)) : 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.mem_en) begin
      chk("mem_req_expected", 40'(exp_mem.size() != 0), 40'd1);
      if (exp_mem.size() != 0) begin
        m_exp = exp_mem.pop_front();
        chk("mem_req", 40'({bus.mem_wr, bus.mem_addr, bus.mem_wr ? bus.mem_wdata : 16'h0000}), 40'(m_exp));
      end
      if (!bus.mem_wr) begin
        pend_cyc.push_back(cyc);
        pend_addr.push_back(bus.mem_addr);
      end
    end
    if (bus.fill_we_i || bus.fill_we_d) begin
      if (bus.fill_we_i) fill_i_cnt++;
      if (bus.fill_we_d) fill_d_cnt++;
      chk("fill_expected", 40'(exp_fill.size() != 0), 40'd1);
      if (exp_fill.size() != 0) begin
        f_exp = exp_fill.pop_front();
        chk("fill_beat", 40'({bus.fill_we_i, bus.fill_we_d, bus.tag_we_i, bus.tag_we_d,
                              bus.fill_word, bus.fill_data}), 40'(f_exp));
      end
    end else if (bus.tag_we_i || bus.tag_we_d) begin
      chk("tag_without_fill", 40'({bus.tag_we_i, bus.tag_we_d}), 40'd0);
    end
  end

  task automatic run_fill(input bit stop_i, input int budget, output int cycles, output int istall_low);
    bit done;
    bit drop_d;
    cycles = 0;
    istall_low = 0;
    done = 1'b0;
    while (!done && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (!bus.istall) istall_low++;
      drop_d = bus.tag_we_d;
      done = stop_i ? bus.tag_we_i : bus.tag_we_d;
      @(posedge clk);
      #2;
      bus.dwrite = 1'b0;
      if (drop_d) bus.dmiss = 1'b0;
      if (stop_i && done) bus.imiss = 1'b0;
    end
    chk("fill_done", 40'(done), 40'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, low, dc, fcnt, icnt;
    bit found;
    bus.imiss = 1'b0; bus.imiss_addr = '0;
    bus.dmiss = 1'b0; bus.dmiss_addr = '0;
    bus.dwrite = 1'b0; bus.dwrite_addr = '0; bus.dwrite_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en", 40'(bus.mem_en), 40'd0);
    chk("rst_mem_wr", 40'(bus.mem_wr), 40'd0);
    chk("rst_mem_addr", 40'(bus.mem_addr), 40'd0);
    chk("rst_mem_wdata", 40'(bus.mem_wdata), 40'd0);
    chk("rst_fill_we", 40'({bus.fill_we_i, bus.fill_we_d}), 40'd0);
    chk("rst_fill_word", 40'(bus.fill_word), 40'd0);
    chk("rst_fill_data", 40'(bus.fill_data), 40'd0);
    chk("rst_tag_we", 40'({bus.tag_we_i, bus.tag_we_d}), 40'd0);
    chk("rst_stall", 40'({bus.istall, bus.dstall}), 40'd0);
    @(posedge clk); #2; rst_n = 1'b1;

    // I-miss at 0x0046: block 0x0040..0x004E, nominal timing.
    @(posedge clk); #2;
    bus.imiss = 1'b1; bus.imiss_addr = 16'h0046;
    push_fill(1'b1, 16'h0046);
    #1 chk("t1_istall_detect", 40'(bus.istall), 40'd1);
    run_fill(1'b1, 40, n, low);
    chk("t1_tag_cycle", 40'(n), 40'd13);
    chk("t1_istall_held", 40'(low), 40'd0);
    @(negedge clk);
    chk("t1_istall_drop", 40'(bus.istall), 40'd0);
    chk("t1_mem_idle", 40'(bus.mem_en), 40'd0);

    // Simultaneous D and I misses: D first, I follows after one IDLE cycle.
    @(posedge clk); #2;
    bus.dmiss = 1'b1; bus.dmiss_addr = 16'h1234;
    bus.imiss = 1'b1; bus.imiss_addr = 16'h0010;
    push_fill(1'b0, 16'h1234);
    push_fill(1'b1, 16'h0010);
    fcnt = fill_d_cnt; icnt = fill_i_cnt;
    run_fill(1'b1, 60, n, low);
    chk("t2_i_tag_cycle", 40'(n), 40'd26);
    chk("t2_istall_held", 40'(low), 40'd0);
    chk("t2_d_beats", 40'(fill_d_cnt - fcnt), 40'd8);
    chk("t2_i_beats", 40'(fill_i_cnt - icnt), 40'd8);
    @(negedge clk);
    chk("t2_istall_drop", 40'(bus.istall), 40'd0);

    // Write-through store.
    @(posedge clk); #2;
    bus.dwrite = 1'b1; bus.dwrite_addr = 16'h2000; bus.dwrite_data = 16'hBEEF;
    exp_mem.push_back({1'b1, 16'h2000, 16'hBEEF});
    dc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.dstall) dc++;
      @(posedge clk); #2;
      bus.dwrite = 1'b0;
    end
    chk("t3_dstall_cycles", 40'(dc), 40'd2);

    // Reset mid-fill after word 3; late beats must be ignored.
    @(posedge clk); #2;
    bus.dmiss = 1'b1; bus.dmiss_addr = 16'h3006;
    push_fill(1'b0, 16'h3006);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk); #1;
      if (bus.fill_we_d && bus.fill_word == 3'd3) found = 1'b1;
    end
    chk("t4_word3_seen", 40'(found), 40'd1);
    chk("t4_pending_fills", 40'(exp_fill.size()), 40'd4);
    exp_fill.delete();
    @(posedge clk); #2;
    rst_n = 1'b0; bus.dmiss = 1'b0;
    fcnt = fill_d_cnt;
    #1;
    chk("t4_rst_mem_en", 40'(bus.mem_en), 40'd0);
    chk("t4_rst_fill", 40'({bus.fill_we_d, bus.tag_we_d, bus.fill_word}), 40'd0);
    chk("t4_rst_fill_data", 40'(bus.fill_data), 40'd0);
    chk("t4_rst_dstall", 40'(bus.dstall), 40'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 40 && pend_cyc.size() != 0; i++) @(posedge clk);
    chk("t4_stale_drained", 40'(pend_cyc.size()), 40'd0);
    repeat (2) @(negedge clk);
    chk("t4_no_stale_fill", 40'(fill_d_cnt - fcnt), 40'd0);
    @(posedge clk); #2;
    bus.dmiss = 1'b1; bus.dmiss_addr = 16'h3006;
    push_fill(1'b0, 16'h3006);
    run_fill(1'b0, 40, n, low);
    chk("t4_refill_tag_cycle", 40'(n), 40'd13);

    // Store and I-miss together: store first, then I fill.
    @(posedge clk); #2;
    bus.dwrite = 1'b1; bus.dwrite_addr = 16'h4002; bus.dwrite_data = 16'h1357;
    bus.imiss = 1'b1; bus.imiss_addr = 16'h0100;
    exp_mem.push_back({1'b1, 16'h4002, 16'h1357});
    push_fill(1'b1, 16'h0100);
    fcnt = fill_d_cnt; icnt = fill_i_cnt;
    run_fill(1'b1, 40, n, low);
    chk("t5_i_tag_cycle", 40'(n), 40'd15);
    chk("t5_istall_held", 40'(low), 40'd0);
    chk("t5_no_d_fill", 40'(fill_d_cnt - fcnt), 40'd0);
    chk("t5_i_beats", 40'(fill_i_cnt - icnt), 40'd8);

    // Irregular valid gaps.
    gap_mode = 1'b1;
    @(posedge clk); #2;
    bus.dmiss = 1'b1; bus.dmiss_addr = 16'h5678;
    push_fill(1'b0, 16'h5678);
    run_fill(1'b0, 80, n, low);
    @(posedge clk); #2;
    bus.imiss = 1'b1; bus.imiss_addr = 16'h0200;
    push_fill(1'b1, 16'h0200);
    run_fill(1'b1, 80, n, low);
    chk("t6_istall_held", 40'(low), 40'd0);
    gap_mode = 1'b0;

    repeat (4) @(negedge clk);
    chk("end_fill_queue_empty", 40'(exp_fill.size()), 40'd0);
    chk("end_mem_queue_empty", 40'(exp_mem.size()), 40'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
